// File: rtl/alsu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module      : alsu_cmd_driver
// Description : Queued command front-end for the combinational 4-bit ALSU;
//               drives operands, samples F/Cout after SETTLE cycles and
//               returns tagged results over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alsu_cmd_driver #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_A,
    input  logic [WIDTH-1:0] cmd_B,
    input  logic             cmd_Cin,
    input  logic [3:0]       cmd_S,
    input  logic [3:0]       cmd_tag,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    output logic [3:0]       S,
    input  logic [WIDTH-1:0] F,
    input  logic             Cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_F,
    output logic             rsp_Cout,
    output logic [3:0]       rsp_S,
    output logic [3:0]       rsp_tag,
    output logic             busy
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = (SETTLE >= 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [c_PTR_W:0]   c_DEPTH  = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_SETTLE = c_CNT_W'(SETTLE);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("alsu_cmd_driver: SETTLE must be at least 1");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("alsu_cmd_driver: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem_a   [DEPTH];
    logic [WIDTH-1:0]   r_mem_b   [DEPTH];
    logic               r_mem_cin [DEPTH];
    logic [3:0]         r_mem_s   [DEPTH];
    logic [3:0]         r_mem_tag [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_done;
    logic w_last;

    // Ready comes from the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign cmd_ready = (r_count < c_DEPTH);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_empty   = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]   <= cmd_A;
            r_mem_b[r_wr_ptr]   <= cmd_B;
            r_mem_cin[r_wr_ptr] <= cmd_Cin;
            r_mem_s[r_wr_ptr]   <= cmd_S;
            r_mem_tag[r_wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_PTR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_PTR_W + 1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [3:0]         r_s;
    logic [3:0]         r_tag;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_f;
    logic               r_rsp_cout;
    logic [3:0]         r_rsp_s;
    logic [3:0]         r_rsp_tag;

    // rsp_valid is high throughout RESP, so rsp_ready alone completes it.
    assign w_done = (r_state == c_ST_RESP) && rsp_ready;
    assign w_pop  = !w_empty && ((r_state == c_ST_IDLE) || w_done);
    assign w_last = (r_cnt == c_CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_cnt   <= c_SETTLE;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_last) begin
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (w_done) begin
                        if (w_pop) begin
                            r_cnt   <= c_SETTLE;
                            r_state <= c_ST_WAIT;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ALSU drive registers change only on a pop and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
            r_s   <= '0;
            r_tag <= '0;
        end else if (w_pop) begin
            r_a   <= r_mem_a[r_rd_ptr];
            r_b   <= r_mem_b[r_rd_ptr];
            r_cin <= r_mem_cin[r_rd_ptr];
            r_s   <= r_mem_s[r_rd_ptr];
            r_tag <= r_mem_tag[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_f     <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_tag   <= '0;
        end else if ((r_state == c_ST_WAIT) && w_last) begin
            r_rsp_valid <= 1'b1;
            r_rsp_f     <= F;
            r_rsp_cout  <= Cout;
            r_rsp_s     <= r_s;
            r_rsp_tag   <= r_tag;
        end else if (w_done) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign Cin       = r_cin;
    assign S         = r_s;
    assign rsp_valid = r_rsp_valid;
    assign rsp_F     = r_rsp_f;
    assign rsp_Cout  = r_rsp_cout;
    assign rsp_S     = r_rsp_s;
    assign rsp_tag   = r_rsp_tag;
    assign busy      = (r_state != c_ST_IDLE) || !w_empty;

endmodule
`default_nettype wire
